mmc5_xram_arb: RTL and testbench

Single-port arbiter and sequencer for the MMC5 1 KB ExRAM. It shares one RAM port among three requesters: PPU fetch/write (highest priority, fixed 1-cycle service), CPU $5C00–$5FFF access, and save-state access. It lives inside the MMC5 mapper in the `mai.clk` domain, so a single-port RAM replaces the dual-clock true-dual-port ExRAM. It also enforces the exram_mode access rules at the RAM port.

---
 rtl/mmc5_pkg.sv | 8 +
 rtl/xram_sp.sv | 17 +
 rtl/mmc5_xram_arb.sv | 111 +++++++++++
 tb/tb_mmc5_xram_arb.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mmc5_pkg.sv
// mmc5_pkg: shared ExRAM widths, mode encodings and grant state type.
package mmc5_pkg;
  localparam int XRAM_AW = 10;
  localparam int XRAM_DW = 8;
  localparam logic [1:0] MODE_RW_CPU = 2'b10;
  localparam logic [1:0] MODE_RO = 2'b11;
  typedef enum logic [1:0] {G_IDLE, G_PPU, G_CPU, G_SST} grant_t;
endpackage

// File: rtl/xram_sp.sv
// xram_sp: single-port synchronous RAM with registered, write-first read.
module xram_sp #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= we ? din : mem[addr];
  end
endmodule

// File: rtl/mmc5_xram_arb.sv
// mmc5_xram_arb: shares one ExRAM port between PPU, CPU and save-state,
// PPU first, with exram_mode gating applied at the RAM port.
module mmc5_xram_arb
  import mmc5_pkg::*;
#(
  parameter int AW = XRAM_AW,
  parameter int DW = XRAM_DW,
  parameter int CPU_MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          map_rst_n,
  input  logic [1:0]    exram_mode,
  input  logic          sst_act,
  input  logic          ppu_req,
  input  logic          ppu_we,
  input  logic [AW-1:0] ppu_addr,
  input  logic [DW-1:0] ppu_din,
  output logic          ppu_vld,
  output logic [DW-1:0] ppu_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  input  logic          sst_req,
  input  logic          sst_we,
  input  logic [AW-1:0] sst_addr,
  input  logic [DW-1:0] sst_din,
  output logic          sst_ack,
  output logic [DW-1:0] sst_dout,
  output logic          cpu_pend,
  output logic          err_ovr,
  output logic          err_drop
);
  localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);
  grant_t g_q, g_d;
  logic mode_b1, cpu_take, sst_take, cpu_zero_d, cpu_zero_q, ram_we;
  logic cpu_we_q, sst_pend, sst_we_q;
  logic [AW-1:0] cpu_addr_q, sst_addr_q, ram_addr;
  logic [DW-1:0] cpu_din_q, sst_din_q, ram_din, ram_q, ppu_hold, cpu_hold, sst_hold;
  logic [3:0] wait_q;
  always_comb begin
    mode_b1 = (exram_mode & MODE_RW_CPU) != 2'b00;
    g_d = (ppu_req && !sst_act) ? G_PPU : cpu_pend ? G_CPU : sst_pend ? G_SST : G_IDLE;
    ram_addr = (g_d == G_PPU) ? ppu_addr : (g_d == G_CPU) ? cpu_addr_q : sst_addr_q;
    ram_din = (g_d == G_PPU) ? ppu_din : (g_d == G_CPU) ? cpu_din_q : sst_din_q;
    ram_we = (g_d == G_PPU) ? (ppu_we && !mode_b1) :
             (g_d == G_CPU) ? (cpu_we_q && exram_mode != MODE_RO && !sst_act) :
             ((g_d == G_SST) && sst_we_q);
    cpu_zero_d = sst_act || (!cpu_we_q && !mode_b1);
    cpu_take = cpu_req && (!cpu_pend || g_d == G_CPU);
    sst_take = sst_req && (!sst_pend || g_d == G_SST);
  end
  always_ff @(posedge clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      g_q <= G_IDLE;
      cpu_zero_q <= 1'b0;
      cpu_pend <= 1'b0;
      cpu_we_q <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q <= '0;
      sst_pend <= 1'b0;
      sst_we_q <= 1'b0;
      sst_addr_q <= '0;
      sst_din_q <= '0;
      wait_q <= '0;
      err_ovr <= 1'b0;
      err_drop <= 1'b0;
      ppu_hold <= '0;
      cpu_hold <= '0;
      sst_hold <= '0;
    end else begin
      g_q <= g_d;
      cpu_zero_q <= cpu_zero_d;
      if (cpu_take) begin
        cpu_pend <= 1'b1;
        cpu_we_q <= cpu_we;
        cpu_addr_q <= cpu_addr;
        cpu_din_q <= cpu_din;
      end else if (g_d == G_CPU) cpu_pend <= 1'b0;
      if (sst_take) begin
        sst_pend <= 1'b1;
        sst_we_q <= sst_we;
        sst_addr_q <= sst_addr;
        sst_din_q <= sst_din;
      end else if (g_d == G_SST) sst_pend <= 1'b0;
      // saturating wait count; restarts whenever the CPU entry is granted
      wait_q <= (cpu_pend && g_d != G_CPU) ? wait_q + 4'(wait_q != 4'hf) : '0;
      err_ovr <= err_ovr || (cpu_pend && wait_q == WAIT_MAX);
      err_drop <= err_drop || (cpu_req && cpu_pend && g_d != G_CPU) ||
                  (sst_req && sst_pend && g_d != G_SST);
      if (ppu_vld) ppu_hold <= ppu_dout;
      if (cpu_ack) cpu_hold <= cpu_dout;
      if (sst_ack) sst_hold <= sst_dout;
    end
  end
  assign ppu_vld = g_q == G_PPU;
  assign cpu_ack = g_q == G_CPU;
  assign sst_ack = g_q == G_SST;
  assign ppu_dout = ppu_vld ? ram_q : ppu_hold;
  assign cpu_dout = cpu_ack ? (cpu_zero_q ? '0 : ram_q) : cpu_hold;
  assign sst_dout = sst_ack ? ram_q : sst_hold;
  xram_sp #(.AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_q)
  );
endmodule

// File: tb/tb_mmc5_xram_arb.sv
// tb_mmc5_xram_arb: directed plus random stimulus against a memory-level reference model.
module tb_mmc5_xram_arb;
  localparam int CPU_MAX_WAIT = 15;
  typedef struct packed {logic we; logic [9:0] addr; logic [7:0] din;} ent_t;
  logic clk = 1'b0, map_rst_n = 1'b0, sst_act = 1'b0;
  logic [1:0] mode = 2'b10;
  logic ppu_req = 0, ppu_we = 0, cpu_req = 0, cpu_we = 0, sst_req = 0, sst_we = 0;
  logic [9:0] ppu_addr = 0, cpu_addr = 0, sst_addr = 0;
  logic [7:0] ppu_din = 0, cpu_din = 0, sst_din = 0;
  logic ppu_vld, cpu_ack, sst_ack, cpu_pend, err_ovr, err_drop;
  logic [7:0] ppu_dout, cpu_dout, sst_dout;
  int n_vec = 0, n_bad = 0, ncyc = 0, mc_since = 0;
  logic [7:0] mem [1024];
  ent_t mc, ms;
  bit mc_pend, ms_pend, m_ovr, m_drop, e_pvld, e_cack, e_sack;
  logic [7:0] e_pd, e_cd, e_sd, saved;
  always #5 clk = ~clk;
  mmc5_xram_arb #(.CPU_MAX_WAIT(CPU_MAX_WAIT)) dut (
    .clk(clk), .map_rst_n(map_rst_n), .exram_mode(mode), .sst_act(sst_act),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_din(ppu_din),
    .ppu_vld(ppu_vld), .ppu_dout(ppu_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .sst_req(sst_req), .sst_we(sst_we), .sst_addr(sst_addr), .sst_din(sst_din),
    .sst_ack(sst_ack), .sst_dout(sst_dout),
    .cpu_pend(cpu_pend), .err_ovr(err_ovr), .err_drop(err_drop)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, ncyc, got, exp);
    end
  endtask
  // Each response's dout is the RAM content right after its access.
  task automatic model_step();
    bit gp, gc, gs;
    gp = ppu_req && !sst_act;
    gc = !gp && mc_pend;
    gs = !gp && !gc && ms_pend;
    if (mc_pend && (ncyc - mc_since) >= CPU_MAX_WAIT) m_ovr = 1;
    if ((cpu_req && mc_pend && !gc) || (sst_req && ms_pend && !gs)) m_drop = 1;
    e_pvld = gp; e_cack = gc; e_sack = gs;
    if (gp) begin
      if (ppu_we && !mode[1]) mem[ppu_addr] = ppu_din;
      e_pd = mem[ppu_addr];
    end
    if (gc) begin
      if (mc.we && mode != 2'b11 && !sst_act) mem[mc.addr] = mc.din;
      e_cd = (sst_act || (!mc.we && !mode[1])) ? 8'h00 : mem[mc.addr];
      mc_pend = 0;
    end
    if (gs) begin
      if (ms.we) mem[ms.addr] = ms.din;
      e_sd = mem[ms.addr];
      ms_pend = 0;
    end
    if (cpu_req && !mc_pend) begin mc_pend = 1; mc = '{cpu_we, cpu_addr, cpu_din}; mc_since = ncyc + 1; end
    if (sst_req && !ms_pend) begin ms_pend = 1; ms = '{sst_we, sst_addr, sst_din}; end
    ncyc++;
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("ppu_vld", ppu_vld, e_pvld);
    chk("ppu_dout", ppu_dout, e_pd);
    chk("cpu_ack", cpu_ack, e_cack);
    chk("cpu_dout", cpu_dout, e_cd);
    chk("sst_ack", sst_ack, e_sack);
    chk("sst_dout", sst_dout, e_sd);
    chk("cpu_pend", cpu_pend, mc_pend);
    chk("err_ovr", err_ovr, m_ovr);
    chk("err_drop", err_drop, m_drop);
    model_step();
    @(posedge clk);
    #1;
    ppu_req = 0; cpu_req = 0; sst_req = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic set_ppu(input logic we, input logic [9:0] a, input logic [7:0] d);
    ppu_req = 1; ppu_we = we; ppu_addr = a; ppu_din = d;
  endtask
  task automatic set_cpu(input logic we, input logic [9:0] a, input logic [7:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_din = d;
  endtask
  task automatic set_sst(input logic we, input logic [9:0] a, input logic [7:0] d);
    sst_req = 1; sst_we = we; sst_addr = a; sst_din = d;
  endtask
  task automatic do_reset();
    @(negedge clk);
    map_rst_n = 0; ppu_req = 0; cpu_req = 0; sst_req = 0;
    #1;
    chk("rst_async_pend", cpu_pend, 0);
    chk("rst_async_ack", {ppu_vld, cpu_ack, sst_ack}, 0);
    chk("rst_async_dout", {ppu_dout, cpu_dout, sst_dout}, 0);
    chk("rst_async_err", {err_ovr, err_drop}, 0);
    mc_pend = 0; ms_pend = 0; m_ovr = 0; m_drop = 0;
    e_pvld = 0; e_cack = 0; e_sack = 0; e_pd = 0; e_cd = 0; e_sd = 0;
    repeat (3) @(posedge clk);
    #1 map_rst_n = 1;
  endtask
  initial begin
    do_reset();
    for (int a = 0; a < 1024; a++) begin set_sst(1, 10'(a), 8'($urandom)); cyc(); end
    set_sst(1, 10'h123, 8'ha5); cyc(); idle(2);
    for (int i = 0; i < 64; i++) begin
      set_ppu(0, 10'h123, 8'h00); cyc();
      chk("ppu_b2b", {ppu_vld, ppu_dout}, {1'b1, 8'ha5});
    end
    mode = 2'b10;
    set_ppu(0, 10'h001, 0); set_cpu(1, 10'h010, 8'h3c); cyc();
    for (int i = 0; i < 4; i++) begin set_ppu(0, 10'(i), 0); cyc(); end
    chk("cont_pend", cpu_pend, 1);
    idle(3);
    set_sst(0, 10'h010, 0); cyc(); idle(2);
    chk("cont_sst_rd", sst_dout, 8'h3c);
    set_sst(1, 10'h020, 8'haa); cyc(); idle(2);
    mode = 2'b11; set_cpu(1, 10'h020, 8'h55); cyc(); idle(2);
    mode = 2'b00; set_cpu(0, 10'h020, 0); cyc(); idle(2);
    chk("mode0_cpu_rd", cpu_dout, 8'h00);
    mode = 2'b10; set_sst(0, 10'h020, 0); cyc(); idle(2);
    chk("mode3_no_wr", sst_dout, 8'haa);
    set_sst(1, 10'h030, 8'h11); cyc(); idle(2);
    set_ppu(1, 10'h030, 8'h77); cyc();
    set_sst(0, 10'h030, 0); cyc(); idle(2);
    chk("mode2_ppu_no_wr", sst_dout, 8'h11);
    set_ppu(0, 0, 0); set_cpu(1, 10'h040, 8'h5a); cyc();
    set_ppu(0, 0, 0); set_cpu(1, 10'h040, 8'h00); cyc();
    set_ppu(0, 0, 0); cyc(); idle(3);
    chk("drop_flag", err_drop, 1);
    chk("ovr_clear", err_ovr, 0);
    set_sst(0, 10'h040, 0); cyc(); idle(2);
    chk("drop_kept", sst_dout, 8'h5a);
    set_cpu(0, 10'h040, 0);
    for (int i = 0; i < 20; i++) begin set_ppu(0, 10'(i), 0); cyc(); end
    idle(2);
    chk("ovr_flag", err_ovr, 1);
    set_sst(1, 10'h050, 8'h21); cyc(); idle(2);
    set_ppu(0, 0, 0); set_cpu(1, 10'h050, 8'h66); cyc();
    sst_act = 1; set_ppu(0, 10'h123, 0); cyc();
    chk("sstact_flush", {ppu_vld, cpu_ack, cpu_dout}, {1'b0, 1'b1, 8'h00});
    set_ppu(0, 10'h123, 0); cyc();
    chk("sstact_ppu_ign", ppu_vld, 0);
    set_sst(1, 10'h3ff, 8'h99); cyc();
    set_sst(0, 10'h3ff, 0); cyc(); idle(2);
    chk("sst_rd_3ff", sst_dout, 8'h99);
    sst_act = 0; set_sst(0, 10'h050, 0); cyc(); idle(2);
    chk("sstact_no_wr", sst_dout, 8'h21);
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin mode = 2'($urandom); sst_act = ($urandom_range(0, 7) == 0); end
      if ($urandom_range(0, 9) < 4) set_ppu(1'($urandom), 10'($urandom), 8'($urandom));
      if ($urandom_range(0, 9) < 3) set_cpu(1'($urandom), 10'($urandom), 8'($urandom));
      if ($urandom_range(0, 9) < 2) set_sst(1'($urandom), 10'($urandom), 8'($urandom));
      cyc();
    end
    sst_act = 0; mode = 2'b10; idle(20);
    set_sst(1, 10'h060, 8'h18); cyc(); idle(2);
    set_cpu(1, 10'h060, 8'he7); cyc();
    do_reset();
    set_sst(0, 10'h060, 0); cyc();
    chk("post_rst_pend", cpu_pend, 0);
    idle(2);
    chk("rst_ram_kept", sst_dout, 8'h18);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
